// File: rtl/emu_host_xactor.sv
// Host-side co-emulation transactor: host byte stream -> wrapper stimulus array, one DUT clock, readback -> host.
// Optional EMU_HOST_CHKSUM_EN appends an XOR checksum byte after the output bytes of each vector.
module emu_host_xactor #(
    parameter int NUM_STIM = 3,
    parameter int NUM_OUT  = 2,
    parameter int CLK_HALF = 2
) (
    input  logic       clk_emu,
    input  logic       rst_emu,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] Din_emu,
    input  logic [7:0] Dout_emu,
    output logic [2:0] Addr_emu,
    output logic       load_emu,
    output logic       get_emu,
    output logic       clk_dut,
    output logic       busy
);

    localparam int            TW        = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam logic [TW-1:0] TMR_LOAD  = TW'(CLK_HALF - 1);
    localparam logic [2:0]    LAST_STIM = 3'(NUM_STIM - 1);
    localparam logic [2:0]    LAST_OUT  = 3'(NUM_OUT - 1);

    typedef enum logic [3:0] {
        RECV, WSET, LOAD, CLK_HI, CLK_LO, GET, RADDR, RCAP, SEND
`ifdef EMU_HOST_CHKSUM_EN
        , CHK
`endif
    } state_t;

    state_t        r_state, w_state;
    logic [2:0]    r_idx, w_idx;
    logic [2:0]    w_nxt;
    logic [TW-1:0] r_tmr, w_tmr;
    logic [7:0]    r_shadow [0:7];
    logic          w_shadow_we;
    logic          r_rx_ready, w_rx_ready;
    logic [7:0]    r_tx_data, w_tx_data;
    logic          r_tx_valid, w_tx_valid;
    logic [7:0]    r_din, w_din;
    logic [2:0]    r_addr, w_addr;
    logic          r_load, w_load;
    logic          r_get, w_get;
    logic          r_clk_dut, w_clk_dut;
    logic          r_busy;
`ifdef EMU_HOST_CHKSUM_EN
    logic [7:0]    r_chk, w_chk;
`endif

    assign w_nxt = r_idx + 3'd1;

    // Addr_emu and Din_emu always move together so Din_emu == shadow[Addr_emu];
    // the wrapper's unconditional write then never corrupts its stimulus array.
    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_tmr       = r_tmr;
        w_shadow_we = 1'b0;
        w_rx_ready  = 1'b0;
        w_tx_data   = r_tx_data;
        w_tx_valid  = r_tx_valid;
        w_din       = r_din;
        w_addr      = r_addr;
        w_load      = 1'b0;
        w_get       = 1'b0;
        w_clk_dut   = 1'b0;
`ifdef EMU_HOST_CHKSUM_EN
        w_chk       = r_chk;
`endif
        case (r_state)
            RECV: begin
                w_rx_ready = 1'b1;
                if (rx_valid && r_rx_ready) begin
                    w_shadow_we = 1'b1;
                    w_din       = rx_data;
                    w_addr      = r_idx;
                    if (r_idx == LAST_STIM) begin
                        w_rx_ready = 1'b0;
                        w_idx      = 3'd0;
                        w_state    = WSET;
                    end else begin
                        w_idx = w_nxt;
                    end
                end
            end
            WSET: begin
                w_load  = 1'b1;
                w_state = LOAD;
            end
            LOAD: begin
                w_clk_dut = 1'b1;
                w_tmr     = TMR_LOAD;
                w_state   = CLK_HI;
            end
            CLK_HI: begin
                if (r_tmr == '0) begin
                    w_tmr   = TMR_LOAD;
                    w_state = CLK_LO;
                end else begin
                    w_clk_dut = 1'b1;
                    w_tmr     = r_tmr - 1'b1;
                end
            end
            CLK_LO: begin
                if (r_tmr == '0) begin
                    w_get   = 1'b1;
                    w_state = GET;
                end else begin
                    w_tmr = r_tmr - 1'b1;
                end
            end
            GET: begin
                w_idx   = 3'd0;
                w_addr  = 3'd0;
                w_din   = r_shadow[0];
`ifdef EMU_HOST_CHKSUM_EN
                w_chk   = 8'h00;
`endif
                w_state = RADDR;
            end
            RADDR: w_state = RCAP;
            RCAP: begin
                w_tx_data  = Dout_emu;
                w_tx_valid = 1'b1;
`ifdef EMU_HOST_CHKSUM_EN
                w_chk      = r_chk ^ Dout_emu;
`endif
                w_state    = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    w_tx_valid = 1'b0;
                    if (r_idx == LAST_OUT) begin
                        w_idx = 3'd0;
`ifdef EMU_HOST_CHKSUM_EN
                        w_state = CHK;
`else
                        w_rx_ready = 1'b1;
                        w_state    = RECV;
`endif
                    end else begin
                        w_idx   = w_nxt;
                        w_addr  = w_nxt;
                        w_din   = r_shadow[w_nxt];
                        w_state = RADDR;
                    end
                end
            end
`ifdef EMU_HOST_CHKSUM_EN
            CHK: begin
                if (!r_tx_valid) begin
                    w_tx_valid = 1'b1;
                    w_tx_data  = r_chk;
                end else if (tx_ready) begin
                    w_tx_valid = 1'b0;
                    w_rx_ready = 1'b1;
                    w_state    = RECV;
                end
            end
`endif
            default: w_state = RECV;
        endcase
    end

    always_ff @(posedge clk_emu or posedge rst_emu) begin
        if (rst_emu) begin
            r_state    <= RECV;
            r_idx      <= 3'd0;
            r_tmr      <= '0;
            r_rx_ready <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_din      <= 8'h00;
            r_addr     <= 3'd0;
            r_load     <= 1'b0;
            r_get      <= 1'b0;
            r_clk_dut  <= 1'b0;
            r_busy     <= 1'b0;
            for (int k = 0; k < 8; k++) r_shadow[k] <= 8'h00;
`ifdef EMU_HOST_CHKSUM_EN
            r_chk      <= 8'h00;
`endif
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_tmr      <= w_tmr;
            r_rx_ready <= w_rx_ready;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_din      <= w_din;
            r_addr     <= w_addr;
            r_load     <= w_load;
            r_get      <= w_get;
            r_clk_dut  <= w_clk_dut;
            r_busy     <= (w_state != RECV);
            if (w_shadow_we) r_shadow[r_idx] <= rx_data;
`ifdef EMU_HOST_CHKSUM_EN
            r_chk      <= w_chk;
`endif
        end
    end

    assign rx_ready = r_rx_ready;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign Din_emu  = r_din;
    assign Addr_emu = r_addr;
    assign load_emu = r_load;
    assign get_emu  = r_get;
    assign clk_dut  = r_clk_dut;
    assign busy     = r_busy;

endmodule

// File: doc/emu_host_xactor.md
# emu_host_xactor

Host-side emulation transactor that drives the byte-wide co-emulation port of a DUT wrapper (Din_emu/Addr_emu/load_emu/get_emu/clk_dut in, Dout_emu back). It takes stimulus vectors from a host byte stream, such as a UART receiver, and writes them into the wrapper's stimulus array. It then applies one DUT clock, captures the DUT outputs, and returns them on a host byte stream. It sits in the emulator FPGA between the host link and the DUT wrapper, in the clk_emu domain.

## Interface
- NUM_STIM, 3: stimulus bytes per vector (1..8)
- NUM_OUT, 2: output bytes per vector (1..8)
- CLK_HALF, 2: clk_emu cycles per clk_dut phase (≥1)

Ports:
- clk_emu  in  1  emulator clock; the single clock of this block
- rst_emu  in  1  asynchronous, active-high reset
- rx_data  in  8  host stimulus byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts rx_data
- tx_data  out  8  response byte to host
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  host accepts tx_data
- Din_emu  out  8  byte to wrapper stimulus array
- Dout_emu  in  8  byte from wrapper output array; registered in the wrapper, 1-cycle read latency
- Addr_emu  out  3  wrapper array index
- load_emu  out  1  one-cycle pulse: wrapper applies its stimulus array to DUT inputs
- get_emu  out  1  one-cycle pulse: wrapper captures DUT outputs
- clk_dut  out  1  generated DUT clock
- busy  out  1  high whenever the state is not RECV

## Operation
- All outputs are registered. Reset value of every output is 0, and the state is RECV. rx_ready goes to 1 on the first clk_emu edge after reset release.
- Wrapper contract:
  - On every clk_emu edge where load_emu=0 and get_emu=0, the wrapper writes stimIn[Addr_emu]<=Din_emu and Dout_emu<=vectOut[Addr_emu].
  - Invariant: Din_emu always equals shadow[Addr_emu], where shadow is an internal copy of the stimulus bytes. This keeps wrapper stimulus intact during readback.
- States:
  - RECV: rx_ready=1. On each rx_valid&&rx_ready, set shadow[i], Din_emu and Addr_emu from rx_data and i, then i++. After byte NUM_STIM-1 is accepted, clear rx_ready and go to WSET.
  - WSET: 1 cycle, so the wrapper writes the last byte.
  - LOAD: load_emu=1 for 1 cycle.
  - CLK_HI: clk_dut=1 for CLK_HALF cycles.
  - CLK_LO: clk_dut=0 for CLK_HALF cycles.
  - GET: get_emu=1 for 1 cycle. j=0.
  - RADDR: Addr_emu=j and Din_emu=shadow[j] for 1 cycle.
  - RCAP: 1 cycle. At the end of the cycle, tx_data<=Dout_emu and tx_valid<=1.
  - SEND: hold tx_data/tx_valid until tx_ready. On the handshake, drop tx_valid and j++. If j<NUM_OUT, go to RADDR; otherwise go to CHK or RECV.
- rx_valid outside RECV is ignored; no byte is consumed.
- load_emu, get_emu and clk_dut=1 are mutually exclusive in time.
- Reset mid-operation:
  - clk_dut, load_emu, get_emu, tx_valid and rx_ready drop immediately.
  - Partial rx vectors and pending tx bytes are discarded.
  - Shadow is cleared to 0.

## Timing
- Last rx handshake at cycle 0 gives:
  - WSET at 1, LOAD at 2
  - clk_dut high at 3..2+CLK_HALF, rising edge visible at 3
  - GET at 3+2·CLK_HALF
  - first tx_valid at 6+2·CLK_HALF (10 with defaults)
- With tx_ready held high, each further output byte follows 3 cycles after the previous handshake (RADDR, RCAP, SEND).
- tx_data is stable while tx_valid=1 and tx_ready=0.
- With defaults and tx_ready=1, the next RECV begins 1 cycle after the last tx handshake.

## Configuration
- EMU_HOST_CHKSUM_EN defined:
  - After the last output byte, state CHK sends one extra byte equal to the XOR of the NUM_OUT output bytes, with the same valid/ready rule.
  - The checksum register clears at GET.
- Undefined: no CHK state; SEND goes straight to RECV after byte NUM_OUT-1.

## Test plan
- Stimulus write: send 0x2A,0x35,0x01 with rx_valid held high → Addr_emu/Din_emu show 0/0x2A, 1/0x35, 2/0x01 on consecutive cycles, and the wrapper model's stimIn equals {0x2A,0x35,0x01} before load_emu.
- Full vector against the wrapper model, with the DUT model returning Yout=9, Xout=3, Vld=1:
  - tx sequence is 0x93, 0x01.
  - With EMU_HOST_CHKSUM_EN, a third byte 0x92 follows.
  - Exactly one load_emu pulse, one clk_dut rising edge and one get_emu pulse occur.
- Latency: with defaults and tx_ready=1 → first tx_valid exactly 10 cycles after the last rx handshake, and clk_dut is high for exactly 2 cycles.
- Backpressure: tx_ready=0 for 5 cycles during byte 0 → tx_data stays 0x93 with tx_valid=1, and no Addr_emu change occurs until the handshake.
- Readback preserves stimulus: after a vector, stimIn in the wrapper model still equals the shadow bytes, and the next vector {0x00,0x00,0x00} overwrites them correctly.
- Async reset asserted mid-CLK_HI → clk_dut=0 and busy=0 without waiting for a clock edge. After release, a new full vector completes normally with no stale tx byte.
